// File: rtl/temp_poll_ctrl.sv
// Conversion scheduler for the DS18B20 path: periodic/manual trigger, bounded wait
// for the core's done pulse, result latching with running min/max and timeout tracking.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a tick, a manual trigger or a pending request
// S_START | conv_start high this cycle; timeout timer reloaded
// S_WAIT  | waiting for conv_done under the timeout timer
// S_LATCH | sample latched last cycle; fold it into min/max
module temp_poll_ctrl #(
    parameter int PERIOD_CYC  = 27_000_000,
    parameter int TIMEOUT_CYC = 27_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        force_req,
    input  logic        clr_err,
    output logic        conv_start,
    input  logic        conv_done,
    input  logic [15:0] conv_data,
    output logic [15:0] temp_out,
    output logic        temp_valid,
    output logic [15:0] temp_min,
    output logic [15:0] temp_max,
    output logic        err_timeout,
    output logic [3:0]  fail_cnt,
    output logic [7:0]  sample_cnt
);

    localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [PW-1:0] PERIOD_TC  = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_TC = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] tick_cnt;
    logic [TW-1:0] to_cnt;
    logic          pending;
    logic          have_sample;
    logic          tick;
    logic          req;
    logic          good_hit;
    logic          timeout_hit;

    // Down-counting sample timer: reloads while disabled, fires at terminal count.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            tick_cnt <= PERIOD_TC;
        end else if (tick_cnt == '0) begin
            tick_cnt <= PERIOD_TC;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    assign tick        = enable && (tick_cnt == '0);
    assign req         = tick || force_req;
    assign good_hit    = (state == S_WAIT) && conv_done;
    assign timeout_hit = (state == S_WAIT) && !conv_done && (to_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            to_cnt      <= TIMEOUT_TC;
            pending     <= 1'b0;
            have_sample <= 1'b0;
            conv_start  <= 1'b0;
            temp_valid  <= 1'b0;
            temp_out    <= 16'h0000;
            temp_min    <= 16'h0000;
            temp_max    <= 16'h0000;
            err_timeout <= 1'b0;
            fail_cnt    <= 4'd0;
            sample_cnt  <= 8'd0;
        end else begin
            conv_start <= 1'b0;
            temp_valid <= 1'b0;
            if (req) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pending || req) begin
                        state      <= S_START;
                        conv_start <= 1'b1;
                        pending    <= 1'b0;
                    end
                end
                S_START: begin
                    to_cnt <= TIMEOUT_TC;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (conv_done) begin
                        temp_out   <= conv_data;
                        temp_valid <= 1'b1;
                        sample_cnt <= sample_cnt + 8'd1;
                        state      <= S_LATCH;
                    end else if (to_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                S_LATCH: begin
                    // temp_out already holds the new sample; the first one seeds both extremes.
                    if (!have_sample || ($signed(temp_out) < $signed(temp_min))) begin
                        temp_min <= temp_out;
                    end
                    if (!have_sample || ($signed(temp_out) > $signed(temp_max))) begin
                        temp_max <= temp_out;
                    end
                    have_sample <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (clr_err) begin
                err_timeout <= 1'b0;
                fail_cnt    <= 4'd0;
            end else if (timeout_hit) begin
                err_timeout <= 1'b1;
                if (fail_cnt != 4'hF) begin
                    fail_cnt <= fail_cnt + 4'd1;
                end
            end else if (good_hit) begin
                fail_cnt <= 4'd0;
            end
        end
    end

endmodule

// File: doc/temp_poll_ctrl.md
# temp_poll_ctrl

Measurement scheduler for the DS18B20 one-wire thermometer path. Periodically (or on a key press) issues a conversion request to the `termometer` core, waits for completion under a timeout, and latches the 16-bit result for the 7-segment decoders. Also tracks the running min/max and reports timeouts. Sits between the top level (27 MHz clock, KEY/SW inputs) and the thermometer core.

## Interface

- `PERIOD_CYC`, default 27_000_000: sample tick interval in clk cycles (1 s at 27 MHz).
- `TIMEOUT_CYC`, default 27_000_000: maximum clk cycles spent waiting for `conv_done`.
- `clk` in 1: system clock (CLOCK_27 at top level).
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: periodic sampling enable (SW[0]).
- `force` in 1: manual trigger, single-cycle pulse (debounced KEY).
- `clr_err` in 1: clears `err_timeout` and `fail_cnt`.
- `conv_start` out 1: one-cycle conversion request to the thermometer core.
- `conv_done` in 1: one-cycle completion pulse from the core.
- `conv_data` in 16: raw DS18B20 temperature, signed two's complement, 1/16 °C LSB.
- `temp_out` out 16: last good sample.
- `temp_valid` out 1: one-cycle pulse when `temp_out` updates.
- `temp_min`, `temp_max` out 16 each: signed extremes since reset.
- `err_timeout` out 1: sticky timeout flag.
- `fail_cnt` out 4: consecutive timeouts, saturating at 15.
- `sample_cnt` out 8: good samples, wraps 255→0.

## Operation

- Tick counter:
  - Free-running 0..PERIOD_CYC-1 while `enable`=1.
  - Held at 0 while `enable`=0.
  - A tick is generated in the cycle where the count equals PERIOD_CYC-1.
- Pending request (1-deep): set by a tick or by `force`; cleared when START is entered. Multiple requests while one is pending merge into one.
- FSM:
  - IDLE: if pending=1 (or a tick/`force` arrives this cycle), go to START.
  - START: `conv_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: the timeout counter increments each cycle.
    - On `conv_done`: capture `conv_data` and go to LATCH.
    - Otherwise, when the count reaches TIMEOUT_CYC-1: set `err_timeout`, increment `fail_cnt` (saturating), go to IDLE.
    - If `conv_done` and timeout occur in the same cycle, `conv_done` wins.
  - LATCH: update `temp_min`/`temp_max` with a signed compare against `temp_out`. On the first sample since reset, load both min and max. Go to IDLE.
- On a good sample:
  - `temp_out`<=`conv_data`; `temp_valid` pulses.
  - `sample_cnt`++.
  - `fail_cnt`<=0. `err_timeout` stays set until `clr_err`.
- `conv_done` outside WAIT is ignored.
- `clr_err` takes priority over a simultaneous timeout increment: the result is flag=0, cnt=0.
- Ticks and `force` in states other than IDLE only set pending.

## Timing

- Reset values:
  - State IDLE; tick counter and pending cleared.
  - `conv_start`=0, `temp_valid`=0, `err_timeout`=0.
  - `temp_out`=`temp_min`=`temp_max`=16'h0000.
  - `fail_cnt`=0, `sample_cnt`=0.
- All outputs are registered.
- `force` at edge N (state IDLE) → START at N+1 → `conv_start` high during cycle N+1 only.
- `conv_done` at cycle M in WAIT → `temp_out`, `temp_valid`=1 and `sample_cnt` valid at M+1 (`temp_valid` high that one cycle only). `temp_min`/`temp_max` valid at M+2. Back in IDLE at M+2.
- Timeout: entering WAIT at cycle W with no done → `err_timeout`=1 visible at W+TIMEOUT_CYC. A pending request restarts START one cycle later.
- Minimum spacing between `conv_start` pulses: 4 cycles (START, WAIT, LATCH, IDLE).
- Reset asserted mid-WAIT: the next edge returns to IDLE with all reset values. A `conv_done` in that same cycle is dropped.

## Test plan

(PERIOD_CYC=20, TIMEOUT_CYC=10)

1. Reset, then `enable`=1 with a model returning done 5 cycles after start and data 0x0191. Expect `conv_start` pulses every 20 cycles, `temp_out`=0x0191, `temp_valid` exactly one cycle per sample, `sample_cnt` incrementing.
2. Data sequence 0x0191, 0xFF5E, 0x07D0. Expect `temp_min`=0xFF5E, `temp_max`=0x07D0 (signed compare); after the first sample min=max=0x0191.
3. Model never responds. Expect `err_timeout`=1 exactly 10 cycles after WAIT entry, `fail_cnt` reaching 15 and holding. A `clr_err` pulse returns both to 0.
4. `force` pulsed 3 times during WAIT. Expect exactly one extra `conv_start` after LATCH; a `force` in IDLE gives `conv_start` on the next cycle.
5. `conv_done` coincident with the timeout cycle. Expect a good sample and no error. A `conv_done` while in IDLE has no effect.
6. Reset asserted in WAIT with `conv_done` in the same cycle. Expect all reset values next cycle and no `temp_valid`. 300 good samples → `sample_cnt`=44 (wrap).
